multicycle_controller: RTL and testbench

// - Multi-cycle sequencer for the LEGv8 datapath: one FSM steps fetch/decode/execute/memory/writeback.
// - Decodes the 11-bit opcode from the instruction register.
// - Drives imm_sel to the sign extender (D/CB/B formats), plus ALU, register-file, memory and PC enables.
// - Owns the memory handshake and its timeout.

---
 rtl/multicycle_controller.sv | 227 ++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Multi-cycle LEGv8 control sequencer: fetch/decode/execute/memory/writeback FSM with memory handshake timeout.
// Optional build macro ILLEGAL_TRAP_EN: unknown opcodes park the FSM in TRAP until reset instead of acting as a NOP.
module multicycle_controller #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [10:0] opcode,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_read,
    output logic        mem_write,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_src,
    output logic        reg_write,
    output logic        alu_src,
    output logic [1:0]  alu_op,
    output logic [1:0]  imm_sel,
    output logic        mem_to_reg,
    output logic        retire,
    output logic        mem_error,
    output logic        illegal,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_BRANCH = 3'd6,
        S_TRAP   = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        C_NOP   = 3'd0,
        C_RTYPE = 3'd1,
        C_LDUR  = 3'd2,
        C_STUR  = 3'd3,
        C_CBZ   = 3'd4,
        C_B     = 3'd5
    } class_t;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_PASSB = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] IMM_NONE = 2'b00;
    localparam logic [1:0] IMM_D    = 2'b01;
    localparam logic [1:0] IMM_CB   = 2'b10;
    localparam logic [1:0] IMM_B    = 2'b11;

    localparam logic [7:0] TIMEOUT_LIMIT = 8'(MEM_TIMEOUT);
    localparam bit         TIMEOUT_EN    = (MEM_TIMEOUT != 0);

    state_t     state_reg;
    state_t     state_next;
    class_t     class_reg;
    class_t     dec_class;
    logic [7:0] wait_reg;
    logic [7:0] wait_next;
    logic       waiting;
    logic       timeout;

    // Opcode classification; only consulted while the FSM sits in DECODE.
    always_comb begin
        dec_class = C_NOP;
        casez (opcode)
            11'b10001011000,
            11'b11001011000,
            11'b10001010000,
            11'b10101010000: dec_class = C_RTYPE;
            11'b11111000010: dec_class = C_LDUR;
            11'b11111000000: dec_class = C_STUR;
            11'b10110100???: dec_class = C_CBZ;
            11'b000101?????: dec_class = C_B;
            default:         dec_class = C_NOP;
        endcase
    end

    // A ready in the same cycle as the limit always wins over the timeout.
    assign waiting = ((state_reg == S_FETCH) || (state_reg == S_MEM)) && !mem_ready;
    assign timeout = waiting && TIMEOUT_EN && (wait_reg == TIMEOUT_LIMIT);

    // Counter is zero whenever no access is stalled, so entry to FETCH/MEM always starts from 0.
    always_comb begin
        wait_next = 8'd0;
        if (waiting && !timeout) begin
            wait_next = (wait_reg == 8'hFF) ? wait_reg : wait_reg + 8'd1;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: state_next = S_FETCH;
            S_FETCH: begin
                if (mem_ready) begin
                    state_next = S_DECODE;
                end else begin
                    state_next = S_FETCH;
                end
            end
            S_DECODE: begin
                case (dec_class)
                    C_RTYPE, C_LDUR, C_STUR: state_next = S_EXEC;
                    C_CBZ, C_B:              state_next = S_BRANCH;
                    default: begin
`ifdef ILLEGAL_TRAP_EN
                        state_next = S_TRAP;
`else
                        state_next = S_FETCH;
`endif
                    end
                endcase
            end
            S_EXEC: begin
                case (class_reg)
                    C_RTYPE:        state_next = S_WB;
                    C_LDUR, C_STUR: state_next = S_MEM;
                    default:        state_next = S_FETCH;
                endcase
            end
            S_MEM: begin
                if (mem_ready) begin
                    state_next = (class_reg == C_LDUR) ? S_WB : S_FETCH;
                end else if (timeout) begin
                    state_next = S_FETCH;
                end else begin
                    state_next = S_MEM;
                end
            end
            S_WB:     state_next = S_FETCH;
            S_BRANCH: state_next = S_FETCH;
            S_TRAP: begin
`ifdef ILLEGAL_TRAP_EN
                state_next = S_TRAP;
`else
                state_next = S_IDLE;
`endif
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= S_IDLE;
            class_reg <= C_NOP;
            wait_reg  <= 8'd0;
        end else begin
            state_reg <= state_next;
            wait_reg  <= wait_next;
            if (state_reg == S_DECODE) begin
                class_reg <= dec_class;
            end
        end
    end

    // Outputs decode straight from the state register, so an asynchronous reset clears them at once.
    always_comb begin
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        reg_write  = 1'b0;
        alu_src    = 1'b0;
        alu_op     = ALU_ADD;
        imm_sel    = IMM_NONE;
        mem_to_reg = 1'b0;
        retire     = 1'b0;
        mem_error  = timeout;
        illegal    = 1'b0;
        case (state_reg)
            S_FETCH: begin
                mem_read = 1'b1;
                ir_write = mem_ready;
                pc_write = mem_ready;
            end
            S_DECODE: begin
                illegal = (dec_class == C_NOP);
`ifndef ILLEGAL_TRAP_EN
                retire  = (dec_class == C_NOP);
`endif
            end
            S_EXEC: begin
                if (class_reg == C_RTYPE) begin
                    alu_op = ALU_FUNCT;
                end else if ((class_reg == C_LDUR) || (class_reg == C_STUR)) begin
                    alu_src = 1'b1;
                    imm_sel = IMM_D;
                end
            end
            S_MEM: begin
                imm_sel   = IMM_D;
                mem_read  = (class_reg == C_LDUR);
                mem_write = (class_reg == C_STUR);
                retire    = (class_reg == C_STUR) && mem_ready;
            end
            S_WB: begin
                reg_write  = 1'b1;
                retire     = 1'b1;
                mem_to_reg = (class_reg == C_LDUR);
            end
            S_BRANCH: begin
                pc_src = 1'b1;
                retire = 1'b1;
                if (class_reg == C_CBZ) begin
                    imm_sel  = IMM_CB;
                    alu_op   = ALU_PASSB;
                    pc_write = zero;
                end else begin
                    imm_sel  = IMM_B;
                    pc_write = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign state = state_reg;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle comparison of every output against hand-computed vectors.
// Output vector layout: {mr mw irw pcw pcs rw as}_{alu_op}_{imm_sel}_{m2r ret err ill}_{state}.
module tb_multicycle_controller;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [10:0] opcode = 11'd0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_read, mem_write, ir_write, pc_write, pc_src, reg_write, alu_src;
    logic [1:0]  alu_op, imm_sel;
    logic        mem_to_reg, retire, mem_error, illegal;
    logic [2:0]  state;
    logic [17:0] obs;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_CBZ  = 11'b10110100101;
    localparam logic [10:0] OP_B    = 11'b00010100011;
    localparam logic [10:0] OP_BAD  = 11'b11111111111;

    localparam logic [17:0] V_ZERO    = 18'b0000000_00_00_0000_000;
    localparam logic [17:0] V_FETCH   = 18'b1011000_00_00_0000_001;
    localparam logic [17:0] V_FWAIT   = 18'b1000000_00_00_0000_001;
    localparam logic [17:0] V_FTMO    = 18'b1000000_00_00_0010_001;
    localparam logic [17:0] V_DECODE  = 18'b0000000_00_00_0000_010;
    localparam logic [17:0] V_EXEC_R  = 18'b0000000_10_00_0000_011;
    localparam logic [17:0] V_EXEC_M  = 18'b0000001_00_01_0000_011;
    localparam logic [17:0] V_MEM_LD  = 18'b1000000_00_01_0000_100;
    localparam logic [17:0] V_MEM_STW = 18'b0100000_00_01_0000_100;
    localparam logic [17:0] V_MEM_STR = 18'b0100000_00_01_0100_100;
    localparam logic [17:0] V_WB_R    = 18'b0000010_00_00_0100_101;
    localparam logic [17:0] V_WB_LD   = 18'b0000010_00_00_1100_101;
    localparam logic [17:0] V_CBZ_NT  = 18'b0000100_01_10_0100_110;
    localparam logic [17:0] V_CBZ_T   = 18'b0001100_01_10_0100_110;
    localparam logic [17:0] V_BR_B    = 18'b0001100_00_11_0100_110;
    localparam logic [17:0] V_ILL_NOP = 18'b0000000_00_00_0101_010;
    localparam logic [17:0] V_ILL_TRP = 18'b0000000_00_00_0001_010;
    localparam logic [17:0] V_TRAP    = 18'b0000000_00_00_0000_111;

    multicycle_controller #(.MEM_TIMEOUT(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .reg_write  (reg_write),
        .alu_src    (alu_src),
        .alu_op     (alu_op),
        .imm_sel    (imm_sel),
        .mem_to_reg (mem_to_reg),
        .retire     (retire),
        .mem_error  (mem_error),
        .illegal    (illegal),
        .state      (state)
    );

    always #5 clock = ~clock;

    assign obs = {mem_read, mem_write, ir_write, pc_write, pc_src, reg_write, alu_src,
                  alu_op, imm_sel, mem_to_reg, retire, mem_error, illegal, state};

    task automatic check_val(input string tag, input logic [17:0] got, input logic [17:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end else begin
            $display("ok   %s: %b", tag, got);
        end
    endtask

    // One clock cycle: drive inputs on the falling edge, compare shortly after.
    task automatic cyc(input string tag, input logic rdy, input logic z,
                       input logic [10:0] op, input logic [17:0] exp);
        @(negedge clock);
        mem_ready = rdy;
        zero      = z;
        opcode    = op;
        #1;
        check_val(tag, obs, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #1 reset = 1'b1;
        for (int i = 0; i < 3; i++) cyc("reset", 1'b1, 1'b0, OP_ADD, V_ZERO);
        reset = 1'b0;
        #1 check_val("idle", obs, V_ZERO);

        // ADD: IDLE, FETCH, DECODE, EXEC, WB
        cyc("add_fetch",  1'b1, 1'b0, OP_ADD, V_FETCH);
        cyc("add_decode", 1'b1, 1'b0, OP_ADD, V_DECODE);
        cyc("add_exec",   1'b1, 1'b0, OP_ADD, V_EXEC_R);
        cyc("add_wb",     1'b1, 1'b0, OP_ADD, V_WB_R);

        // LDUR with two stalled MEM cycles: 7 cycles total
        cyc("ld_fetch",  1'b1, 1'b0, OP_LDUR, V_FETCH);
        cyc("ld_decode", 1'b1, 1'b0, OP_LDUR, V_DECODE);
        cyc("ld_exec",   1'b1, 1'b0, OP_LDUR, V_EXEC_M);
        cyc("ld_mem_w1", 1'b0, 1'b0, OP_LDUR, V_MEM_LD);
        cyc("ld_mem_w2", 1'b0, 1'b0, OP_LDUR, V_MEM_LD);
        cyc("ld_mem_rd", 1'b1, 1'b0, OP_LDUR, V_MEM_LD);
        cyc("ld_wb",     1'b1, 1'b0, OP_LDUR, V_WB_LD);

        // STUR, no stall: 4 cycles
        cyc("st_fetch",  1'b1, 1'b0, OP_STUR, V_FETCH);
        cyc("st_decode", 1'b1, 1'b0, OP_STUR, V_DECODE);
        cyc("st_exec",   1'b1, 1'b0, OP_STUR, V_EXEC_M);
        cyc("st_mem",    1'b1, 1'b0, OP_STUR, V_MEM_STR);

        // ORR goes through the R-type path
        cyc("orr_fetch",  1'b1, 1'b0, OP_ORR, V_FETCH);
        cyc("orr_decode", 1'b1, 1'b0, OP_ORR, V_DECODE);
        cyc("orr_exec",   1'b1, 1'b0, OP_ORR, V_EXEC_R);
        cyc("orr_wb",     1'b1, 1'b0, OP_ORR, V_WB_R);

        // CBZ not taken, then taken
        cyc("cbz0_fetch",  1'b1, 1'b0, OP_CBZ, V_FETCH);
        cyc("cbz0_decode", 1'b1, 1'b0, OP_CBZ, V_DECODE);
        cyc("cbz0_branch", 1'b1, 1'b0, OP_CBZ, V_CBZ_NT);
        cyc("cbz1_fetch",  1'b1, 1'b1, OP_CBZ, V_FETCH);
        cyc("cbz1_decode", 1'b1, 1'b1, OP_CBZ, V_DECODE);
        cyc("cbz1_branch", 1'b1, 1'b1, OP_CBZ, V_CBZ_T);

        // Unconditional B
        cyc("b_fetch",  1'b1, 1'b0, OP_B, V_FETCH);
        cyc("b_decode", 1'b1, 1'b0, OP_B, V_DECODE);
        cyc("b_branch", 1'b1, 1'b0, OP_B, V_BR_B);

        // Fetch timeout: four waits, error on the fifth, then FETCH again with a fresh counter
        for (int i = 0; i < 4; i++) cyc("tmo_wait", 1'b0, 1'b0, OP_B, V_FWAIT);
        cyc("tmo_error",    1'b0, 1'b0, OP_B, V_FTMO);
        for (int i = 0; i < 4; i++) cyc("tmo_rewait", 1'b0, 1'b0, OP_B, V_FWAIT);
        // Ready arriving on the limit cycle completes the fetch with no error
        cyc("tmo_ready_wins", 1'b1, 1'b0, OP_B, V_FETCH);
        cyc("tmo_b_decode",   1'b1, 1'b0, OP_B, V_DECODE);
        cyc("tmo_b_branch",   1'b1, 1'b0, OP_B, V_BR_B);

        // Reset asserted while STUR waits in MEM: request drops at once
        cyc("rst_st_fetch",  1'b1, 1'b0, OP_STUR, V_FETCH);
        cyc("rst_st_decode", 1'b1, 1'b0, OP_STUR, V_DECODE);
        cyc("rst_st_exec",   1'b1, 1'b0, OP_STUR, V_EXEC_M);
        cyc("rst_st_mem",    1'b0, 1'b0, OP_STUR, V_MEM_STW);
        reset = 1'b1;
        #1 check_val("rst_async_drop", obs, V_ZERO);
        cyc("rst_hold", 1'b1, 1'b0, OP_ADD, V_ZERO);
        reset = 1'b0;
        #1 check_val("rst_idle", obs, V_ZERO);
        cyc("rst_fetch", 1'b1, 1'b0, OP_BAD, V_FETCH);

        // Unknown opcode
`ifdef ILLEGAL_TRAP_EN
        cyc("ill_decode", 1'b1, 1'b0, OP_BAD, V_ILL_TRP);
        for (int i = 0; i < 3; i++) cyc("ill_trap_hold", 1'b1, 1'b0, OP_ADD, V_TRAP);
        reset = 1'b1;
        #1 check_val("ill_trap_reset", obs, V_ZERO);
        cyc("ill_trap_rst_hold", 1'b1, 1'b0, OP_ADD, V_ZERO);
        reset = 1'b0;
        cyc("ill_after_fetch", 1'b1, 1'b0, OP_ADD, V_FETCH);
`else
        cyc("ill_decode",      1'b1, 1'b0, OP_BAD, V_ILL_NOP);
        cyc("ill_after_fetch", 1'b1, 1'b0, OP_ADD, V_FETCH);
        cyc("ill_next_decode", 1'b1, 1'b0, OP_ADD, V_DECODE);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
